// File: rtl/raizing_linetext_pkg.sv
// Shared types and constants for the per-scanline text layer renderer.
package raizing_linetext_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LINE,
        LINE_LAT,
        MAP,
        MAP_LAT,
        ROM0,
        ROM1,
        DRAW,
        NEXT
    } state_t;

    localparam int RAM_LAT = 2;   // row-select / scroll / VRAM read latency
    localparam int TILE_PX = 8;   // pixels per tile row
    localparam int NIB_W   = 4;   // bits per pixel in text ROM
    localparam int BUF_AW  = 9;   // 512-entry line buffer half
    localparam int PIX_W   = 11;  // colour index width

    // Leftmost pixel lives in the top nibble of the 32-bit tile row.
    function automatic logic [NIB_W-1:0] f_nibble(input logic [31:0] tile,
                                                  input logic [2:0]  tx);
        return tile[{3'd7 - tx, 2'b00} +: NIB_W];
    endfunction

endpackage

// File: rtl/raizing_linetext_lbuf.sv
// Ping-pong line buffer: renderer writes the back half while the mixer
// reads the front half; a swap flips the roles.
module raizing_linetext_lbuf
    import raizing_linetext_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_swap,
    input  logic              i_we,
    input  logic [BUF_AW-1:0] i_waddr,
    input  logic [PIX_W-1:0]  i_wdata,
    input  logic              i_rd_en,
    input  logic [BUF_AW-1:0] i_raddr,
    output logic [PIX_W-1:0]  o_rdata
);

    logic                r_front;
    logic [PIX_W-1:0]    r_mem [0:(2**(BUF_AW+1))-1];
    logic [PIX_W-1:0]    r_rdata;

    // Front/back half select, toggled once per line start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_front <= 1'b0;
        else if (i_swap) r_front <= ~r_front;
    end

    // Renderer writes land in the back half.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[{~r_front, i_waddr}] <= i_wdata;
    end

    // Registered pixel-rate read of the front half.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) r_rdata <= r_mem[{r_front, i_raddr}];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/raizing_linetext.sv
// Per-scanline fixed text layer: fetches row select and scroll, walks the
// tilemap, expands 4bpp tile rows from ROM into a ping-pong line buffer and
// serves the front buffer to the mixer at pixel rate.
module raizing_linetext
    import raizing_linetext_pkg::*;
#(
    parameter int          TILES         = 41,
    parameter int          LINE_W        = 320,
    parameter logic [15:0] XOFFS         = 16'h2C,
    parameter logic [10:0] PAL_BASE      = 11'h400,
    parameter int          MAP_COLS_LOG2 = 6
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pixel_cen,
    input  logic        i_hb,
    input  logic        i_vb,
    input  logic [8:0]  i_vrender,
    input  logic [8:0]  i_h,
    input  logic        i_flip,
    input  logic        i_layer_en,
    output logic [10:0] o_pixel_out,
    output logic [7:0]  o_sel_addr,
    input  logic [15:0] i_sel_data,
    output logic [7:0]  o_scr_addr,
    input  logic [15:0] i_scr_data,
    output logic [11:0] o_vram_addr,
    input  logic [15:0] i_vram_data,
    output logic [13:0] o_rom_addr,
    output logic        o_rom_cs,
    input  logic        i_rom_ok,
    input  logic [15:0] i_rom_data,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam logic [7:0] COL_MASK  = 8'((1 << MAP_COLS_LOG2) - 1);
    localparam logic [7:0] TILE_LAST = 8'(TILES - 1);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [7:0]  r_x;
    logic [2:0]  r_tx;
    logic [4:0]  r_row;
    logic [2:0]  r_fy;
    logic [2:0]  r_fine;
    logic [7:0]  r_startx;
    logic [5:0]  r_pal;
    logic [31:0] r_tile;
    logic        r_flip;
    logic        r_busy;
    logic        r_overrun;
    logic [7:0]  r_sel_addr;
    logic [11:0] r_vram_addr;
    logic [13:0] r_rom_addr;
    logic        r_rom_cs;
    logic        r_hb_d;
    logic        r_vis;

    logic              w_start;
    logic [15:0]       w_off;
    logic [7:0]        w_startx;
    logic [9:0]        w_bx;
    logic              w_in_range;
    logic [BUF_AW-1:0] w_waddr;
    logic [NIB_W-1:0]  w_nib;
    logic [PIX_W-1:0]  w_wdata;
    logic              w_we;
    logic [PIX_W-1:0]  w_rd_data;
    logic              w_h_vis;
    logic              w_unused;

    // Tilemap address: row in the upper bits, column wrapped to map width.
    function automatic logic [11:0] f_map_addr(input logic [4:0] row,
                                               input logic [7:0] col);
        return ({7'd0, row} << MAP_COLS_LOG2) | {4'd0, col & COL_MASK};
    endfunction

    // Line start on HB falling edge, outside vblank except for line 0.
    assign w_start  = r_hb_d & ~i_hb & (~i_vb | (i_vrender == 9'd0));

    assign w_off    = i_scr_data + XOFFS;
    assign w_startx = {2'b00, w_off[8:3]} & COL_MASK;

    // Screen X of the current draw pixel; negative values are clipped.
    assign w_bx       = 10'({r_x, 3'b000}) - {7'd0, r_fine} + {7'd0, r_tx};
    assign w_in_range = !w_bx[9] && (w_bx < 10'(LINE_W));
    assign w_waddr    = r_flip ? BUF_AW'(10'(LINE_W - 1) - w_bx) : w_bx[BUF_AW-1:0];
    assign w_nib      = f_nibble(r_tile, r_tx);
    assign w_wdata    = (w_nib == '0) ? '0 : PAL_BASE + {1'b0, r_pal, w_nib};
    // A start event on the same edge swaps halves; drop that stray write.
    assign w_we       = (r_state == DRAW) && w_in_range && !w_start;

    assign w_h_vis    = ({1'b0, i_h} < 10'(LINE_W));

    assign w_unused   = ^{i_sel_data[15:8], w_off[15:9]};

    // HB history for edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_hb_d <= 1'b0;
        else            r_hb_d <= i_hb;
    end

    // Render sequencer: line setup, per-tile map/ROM fetch, pixel draw.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_tx        <= '0;
            r_row       <= '0;
            r_fy        <= '0;
            r_fine      <= '0;
            r_startx    <= '0;
            r_pal       <= '0;
            r_tile      <= '0;
            r_flip      <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_sel_addr  <= '0;
            r_vram_addr <= '0;
            r_rom_addr  <= '0;
            r_rom_cs    <= 1'b0;
        end else if (w_start) begin
            // A start while busy abandons the line in flight.
            if (r_busy) r_overrun <= 1'b1;
            r_flip     <= i_flip;
            r_busy     <= 1'b1;
            r_rom_cs   <= 1'b0;
            r_sel_addr <= i_vrender[7:0];
            r_state    <= LINE;
        end else begin
            case (r_state)
                IDLE: ;
                LINE: begin
                    r_cnt   <= '0;
                    r_x     <= '0;
                    r_state <= LINE_LAT;
                end
                LINE_LAT: begin
                    if (r_cnt == 2'(RAM_LAT - 1)) begin
                        r_row       <= i_sel_data[7:3];
                        r_fy        <= i_sel_data[2:0];
                        r_fine      <= w_off[2:0];
                        r_startx    <= w_startx;
                        r_vram_addr <= f_map_addr(i_sel_data[7:3], w_startx);
                        r_state     <= MAP;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                MAP: begin
                    r_cnt   <= '0;
                    r_state <= MAP_LAT;
                end
                MAP_LAT: begin
                    if (r_cnt == 2'(RAM_LAT - 1)) begin
                        r_pal      <= i_vram_data[15:10];
                        r_rom_addr <= {i_vram_data[9:0], r_fy, 1'b0};
                        r_rom_cs   <= 1'b1;
                        r_state    <= ROM0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ROM0: begin
                    if (i_rom_ok) begin
                        r_tile[31:16] <= i_rom_data;
                        r_rom_cs      <= 1'b0;
                        r_state       <= ROM1;
                    end
                end
                ROM1: begin
                    // First cycle here is the mandatory CS gap.
                    if (!r_rom_cs) begin
                        r_rom_addr <= r_rom_addr + 14'd1;
                        r_rom_cs   <= 1'b1;
                    end else if (i_rom_ok) begin
                        r_tile[15:0] <= i_rom_data;
                        r_rom_cs     <= 1'b0;
                        r_tx         <= '0;
                        r_state      <= DRAW;
                    end
                end
                DRAW: begin
                    r_tx <= r_tx + 3'd1;
                    if (r_tx == 3'(TILE_PX - 1)) r_state <= NEXT;
                end
                NEXT: begin
                    if (r_x == TILE_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_x         <= r_x + 8'd1;
                        r_vram_addr <= f_map_addr(r_row, r_x + 8'd1 + r_startx);
                        r_state     <= MAP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Visibility gate travels alongside the buffer read.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)       r_vis <= 1'b0;
        else if (i_pixel_cen) r_vis <= i_layer_en && w_h_vis;
    end

    raizing_linetext_lbuf u_lbuf (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_swap  (w_start),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_rd_en (i_pixel_cen),
        .i_raddr (i_h),
        .o_rdata (w_rd_data)
    );

    assign o_pixel_out = r_vis ? w_rd_data : '0;
    assign o_sel_addr  = r_sel_addr;
    assign o_scr_addr  = r_sel_addr;
    assign o_vram_addr = r_vram_addr;
    assign o_rom_addr  = r_rom_addr;
    assign o_rom_cs    = r_rom_cs;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;

endmodule
